// File: rtl/fft_input_reorder_pkg.sv
// fft_input_reorder_pkg
//   Shared types and helpers for the FFT input reorder buffer.
//   rd_state_e : reader FSM states
//   clog2()    : ceiling log2, usable in constant expressions
//   bitrev()   : reverse the low 'bits' bits of a value
package fft_input_reorder_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StRead
    } rd_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < value) begin
            res++;
        end
        return res;
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned bits);
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < int'(bits); i++) begin
            res[i] = value[int'(bits) - 1 - i];
        end
        return res;
    endfunction

endpackage

// File: rtl/fft_input_reorder_ram.sv
// fft_input_reorder_ram
//   Simple dual-port RAM: one write port, one registered read port.
//   clk   : clock
//   we    : write enable      waddr/wdata : write address/data
//   re    : read enable       raddr       : read address
//   rdata : read data, valid the cycle after re
module fft_input_reorder_ram #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WIDTH  = 33,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem_q[raddr];
        end
    end

endmodule

// File: rtl/fft_input_reorder.sv
// fft_input_reorder
//   Collects N-sample frames from the filterbank into a ping-pong buffer and
//   replays each frame as a gapless burst in bit-reversed (or natural) order.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_data/in_m/in_first : sample, metadata, filter-0 marker; valid on in_nd
//   out_data/out_m        : reordered sample and metadata; valid on out_nd
//   out_first             : first sample of an output frame
//   error                 : sticky; framing slip or buffer overflow
module fft_input_reorder
    import fft_input_reorder_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned MWIDTH = 1,
    parameter int unsigned BITREV = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_nd,
    input  logic [MWIDTH-1:0] in_m,
    input  logic              in_first,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_nd,
    output logic [MWIDTH-1:0] out_m,
    output logic              out_first,
    output logic              error
);

    localparam int unsigned LOG_N = clog2(N);
    localparam int unsigned DW    = WIDTH + MWIDTH;
    localparam logic [LOG_N-1:0] LastIdx = LOG_N'(N - 1);

    logic             wbank_q, wbank_d;
    logic [LOG_N-1:0] widx_q, widx_d;
    logic [1:0]       full_q, full_d;
    logic             error_q, error_d;

    rd_state_e        state_q;
    logic             rbank_q;
    logic [LOG_N-1:0] ridx_q;

    logic             rd_valid_q, rd_first_q;
    logic             out_nd_q, out_first_q;
    logic [DW-1:0]    out_q;

    // Reader hold; tied off in normal operation.
    logic read_hold;
    assign read_hold = 1'b0;

    logic             issue, issue_last, wr_sync, wr_done, overflow;
    logic [LOG_N-1:0] wr_idx, rd_idx;
    logic [DW-1:0]    ram_rdata;

    always_comb begin
        issue      = (state_q == StRead) && !read_hold;
        issue_last = issue && (ridx_q == LastIdx);
        wr_sync    = in_nd && in_first && (widx_q != '0);
        wr_done    = in_nd && !wr_sync && (widx_q == LastIdx);
        // The other bank is free if empty or its final read issues this cycle.
        overflow   = wr_done && full_q[~wbank_q] && !(issue_last && (rbank_q == ~wbank_q));

        wr_idx = wr_sync ? '0 : widx_q;
        rd_idx = (BITREV != 0) ? LOG_N'(bitrev(32'(ridx_q), LOG_N)) : ridx_q;

        full_d = full_q;
        if (issue_last) begin
            full_d[rbank_q] = 1'b0;
        end
        if (wr_done && !overflow) begin
            full_d[wbank_q] = 1'b1;
        end

        wbank_d = wbank_q;
        widx_d  = widx_q;
        if (in_nd) begin
            if (wr_sync) begin
                widx_d = LOG_N'(1);
            end else if (wr_done) begin
                widx_d = '0;
                if (!overflow) begin
                    wbank_d = ~wbank_q;
                end
            end else begin
                widx_d = widx_q + 1'b1;
            end
        end

        error_d = error_q | wr_sync | overflow;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wbank_q <= 1'b0;
            widx_q  <= '0;
            full_q  <= '0;
            error_q <= 1'b0;
        end else begin
            wbank_q <= wbank_d;
            widx_q  <= widx_d;
            full_q  <= full_d;
            error_q <= error_d;
        end
    end

    // Reader FSM. Looks at full_d so a bank completing this cycle starts
    // reading immediately, keeping back-to-back frames gapless.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rbank_q <= 1'b0;
            ridx_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|full_d) begin
                        state_q <= StRead;
                        rbank_q <= ~full_d[0];
                        ridx_q  <= '0;
                    end
                end
                StRead: begin
                    if (issue_last) begin
                        ridx_q <= '0;
                        if (full_d[~rbank_q]) begin
                            rbank_q <= ~rbank_q;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (issue) begin
                        ridx_q <= ridx_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    fft_input_reorder_ram #(
        .DEPTH  (2 * N),
        .WIDTH  (DW),
        .ADDR_W (LOG_N + 1)
    ) u_ram (
        .clk   (clk),
        .we    (in_nd),
        .waddr ({wbank_q, wr_idx}),
        .wdata ({in_m, in_data}),
        .re    (issue),
        .raddr ({rbank_q, rd_idx}),
        .rdata (ram_rdata)
    );

    // Two stages: RAM read register, then output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_q  <= 1'b0;
            rd_first_q  <= 1'b0;
            out_nd_q    <= 1'b0;
            out_first_q <= 1'b0;
            out_q       <= '0;
        end else begin
            rd_valid_q  <= issue;
            rd_first_q  <= issue && (ridx_q == '0);
            out_nd_q    <= rd_valid_q;
            out_first_q <= rd_valid_q && rd_first_q;
            if (rd_valid_q) begin
                out_q <= ram_rdata;
            end
        end
    end

    assign out_data  = out_q[WIDTH-1:0];
    assign out_m     = out_q[DW-1:WIDTH];
    assign out_nd    = out_nd_q;
    assign out_first = out_first_q;
    assign error     = error_q;

endmodule
